// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch resolution: registered PC redirect, wrong-path flush sequencing,
// JAL/JALR link write-back pulse and saturating resolved/taken performance counters.
module branch_redirect_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic             ex_jal,
    input  logic             branch_con,
    input  logic [15:0]      ex_target,
    input  logic [15:0]      ex_pc2,
    input  logic             clr_cnt,
    output logic             redirect,
    output logic [15:0]      redirect_pc,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             link_we,
    output logic [15:0]      link_data,
    output logic [CNT_W-1:0] resolved_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_INIT = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] fcnt;
    logic [2:0] fcnt_nxt;
    logic       jal_q;
    logic       res;
    logic       take;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Only the first EX slot seen in IDLE is on the correct path.
    assign res  = ex_valid & ex_branch & ~stall & (state == IDLE);
    assign take = res & branch_con;

    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        case (state)
            IDLE: begin
                if (take) state_nxt = REDIRECT;
            end
            REDIRECT: begin
                if (!stall) begin
                    if (FLUSH_CYCLES == 1) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = FLUSH;
                        fcnt_nxt  = FLUSH_INIT;
                    end
                end
            end
            FLUSH: begin
                if (!stall) begin
                    if (fcnt == 3'd0) state_nxt = IDLE;
                    else              fcnt_nxt  = fcnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            fcnt  <= 3'd0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    // Target and link value are captured on the resolve edge and held until the next taken resolve.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirect_pc <= 16'd0;
            link_data   <= 16'd0;
            jal_q       <= 1'b0;
        end else if (take) begin
            redirect_pc <= ex_target;
            jal_q       <= ex_jal;
            if (ex_jal) link_data <= ex_pc2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resolved_cnt <= '0;
            taken_cnt    <= '0;
        end else if (clr_cnt) begin
            resolved_cnt <= '0;
            taken_cnt    <= '0;
        end else if (res) begin
            resolved_cnt <= sat_inc(resolved_cnt);
            if (branch_con) taken_cnt <= sat_inc(taken_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (ex_valid & ex_jal & (~ex_branch | ~branch_con)) begin
            err <= 1'b1;
        end
    end

    assign redirect   = (state == REDIRECT);
    assign flush_ifid = (state != IDLE);
    assign flush_idex = (state != IDLE);
    assign link_we    = (state == REDIRECT) & jal_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: default instance plus a CNT_W=2 /
// FLUSH_CYCLES=1 instance for counter saturation and clear.
module tb_branch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        ex_valid;
    logic        ex_valid2;
    logic        ex_branch;
    logic        ex_jal;
    logic        branch_con;
    logic [15:0] ex_target;
    logic [15:0] ex_pc2;
    logic        clr_cnt;

    logic        redirect, flush_ifid, flush_idex, link_we, err;
    logic [15:0] redirect_pc, link_data;
    logic [15:0] resolved_cnt, taken_cnt;

    logic        redirect2, flush_ifid2, flush_idex2, link_we2, err2;
    logic [15:0] redirect_pc2, link_data2;
    logic [1:0]  resolved_cnt2, taken_cnt2;

    int n_chk  = 0;
    int n_fail = 0;

    branch_redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .ex_branch(ex_branch),
        .ex_jal(ex_jal), .branch_con(branch_con), .ex_target(ex_target), .ex_pc2(ex_pc2),
        .clr_cnt(clr_cnt), .redirect(redirect), .redirect_pc(redirect_pc),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .link_we(link_we),
        .link_data(link_data), .resolved_cnt(resolved_cnt), .taken_cnt(taken_cnt), .err(err)
    );

    branch_redirect_ctrl #(.FLUSH_CYCLES(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid2), .ex_branch(ex_branch),
        .ex_jal(ex_jal), .branch_con(branch_con), .ex_target(ex_target), .ex_pc2(ex_pc2),
        .clr_cnt(clr_cnt), .redirect(redirect2), .redirect_pc(redirect_pc2),
        .flush_ifid(flush_ifid2), .flush_idex(flush_idex2), .link_we(link_we2),
        .link_data(link_data2), .resolved_cnt(resolved_cnt2), .taken_cnt(taken_cnt2), .err(err2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packs {redirect, flush_ifid, flush_idex, link_we} for compact checks.
    function automatic logic [3:0] ctl1();
        return {redirect, flush_ifid, flush_idex, link_we};
    endfunction

    initial begin
        rst = 1'b0; stall = 1'b0; ex_valid = 1'b0; ex_valid2 = 1'b0; ex_branch = 1'b0;
        ex_jal = 1'b0; branch_con = 1'b0; ex_target = 16'h0; ex_pc2 = 16'h0; clr_cnt = 1'b0;

        // Reset state
        #3;
        chk("reset_ctl", 32'(ctl1()), 32'h0);
        chk("reset_pc", 32'(redirect_pc), 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        #9 rst = 1'b1;

        // Idle for 5 cycles
        for (int i = 0; i < 5; i++) tick();
        chk("idle_ctl", 32'(ctl1()), 32'h0);
        chk("idle_resolved", 32'(resolved_cnt), 32'h0);
        chk("idle_taken", 32'(taken_cnt), 32'h0);

        // Not-taken branch
        ex_valid = 1'b1; ex_branch = 1'b1; branch_con = 1'b0; ex_target = 16'h0033;
        tick();
        ex_valid = 1'b0;
        chk("nt_redirect", 32'(redirect), 32'h0);
        chk("nt_resolved", 32'(resolved_cnt), 32'h1);
        chk("nt_taken", 32'(taken_cnt), 32'h0);
        tick();
        chk("nt_redirect2", 32'(redirect), 32'h0);

        // Taken branch to 0x0040; a second taken branch stays presented through REDIRECT/FLUSH
        ex_valid = 1'b1; ex_branch = 1'b1; branch_con = 1'b1; ex_target = 16'h0040;
        tick();
        ex_target = 16'h0080;
        chk("tk_ctl_redirect", 32'(ctl1()), 32'hE);
        chk("tk_pc", 32'(redirect_pc), 32'h0040);
        chk("tk_taken", 32'(taken_cnt), 32'h1);
        tick();
        chk("tk_ctl_flush", 32'(ctl1()), 32'h6);
        chk("tk_pc_hold", 32'(redirect_pc), 32'h0040);
        tick();
        ex_valid = 1'b0;
        chk("tk_ctl_idle", 32'(ctl1()), 32'h0);
        chk("tk_taken_ignored", 32'(taken_cnt), 32'h1);
        chk("tk_resolved", 32'(resolved_cnt), 32'h2);
        tick();
        chk("tk_no_second", 32'(ctl1()), 32'h0);
        chk("tk_pc_final", 32'(redirect_pc), 32'h0040);

        // JAL taken, stalled for 3 cycles in REDIRECT
        ex_valid = 1'b1; ex_branch = 1'b1; ex_jal = 1'b1; branch_con = 1'b1;
        ex_target = 16'h0100; ex_pc2 = 16'h0012;
        tick();
        ex_valid = 1'b0; ex_jal = 1'b0; stall = 1'b1;
        chk("jal_ctl", 32'(ctl1()), 32'hF);
        chk("jal_link", 32'(link_data), 32'h0012);
        chk("jal_pc", 32'(redirect_pc), 32'h0100);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("jal_stall_ctl%0d", i), 32'(ctl1()), 32'hF);
        end
        stall = 1'b0;
        tick();
        chk("jal_flush_ctl", 32'(ctl1()), 32'h6);
        chk("jal_link_hold", 32'(link_data), 32'h0012);
        tick();
        chk("jal_idle_ctl", 32'(ctl1()), 32'h0);
        chk("jal_resolved", 32'(resolved_cnt), 32'h3);
        chk("jal_taken", 32'(taken_cnt), 32'h2);
        chk("jal_err", 32'(err), 32'h0);

        // Set err while held in FLUSH, then reset asynchronously mid-cycle
        ex_valid = 1'b1; ex_branch = 1'b1; branch_con = 1'b1; ex_target = 16'h0200;
        tick();
        ex_valid = 1'b0;
        tick();
        chk("rs_in_flush", 32'(ctl1()), 32'h6);
        ex_valid = 1'b1; ex_jal = 1'b1; ex_branch = 1'b0; stall = 1'b1;
        tick();
        ex_valid = 1'b0; ex_jal = 1'b0;
        chk("rs_err_set", 32'(err), 32'h1);
        chk("rs_still_flush", 32'(ctl1()), 32'h6);
        #3 rst = 1'b0;
        #1;
        chk("rs_async_ctl", 32'(ctl1()), 32'h0);
        chk("rs_async_err", 32'(err), 32'h0);
        chk("rs_async_pc", 32'(redirect_pc), 32'h0);
        chk("rs_async_cnt", 32'(resolved_cnt), 32'h0);
        #2 rst = 1'b1;
        stall = 1'b0;
        tick();
        chk("rs_idle_ctl", 32'(ctl1()), 32'h0);
        chk("rs_idle_err", 32'(err), 32'h0);

        // Saturation on the CNT_W=2 instance
        ex_branch = 1'b1; branch_con = 1'b1; ex_jal = 1'b0; ex_target = 16'h0400;
        for (int i = 0; i < 5; i++) begin
            ex_valid2 = 1'b1;
            tick();
            ex_valid2 = 1'b0;
            if (i == 0) begin
                chk("sat_first_redirect", 32'(redirect2), 32'h1);
                chk("sat_first_resolved", 32'(resolved_cnt2), 32'h1);
            end
            tick();
            if (i == 0) chk("sat_fc1_idle", 32'({redirect2, flush_ifid2}), 32'h0);
        end
        chk("sat_resolved", 32'(resolved_cnt2), 32'h3);
        chk("sat_taken", 32'(taken_cnt2), 32'h3);
        ex_valid2 = 1'b1; clr_cnt = 1'b1;
        tick();
        ex_valid2 = 1'b0; clr_cnt = 1'b0;
        chk("clr_resolved", 32'(resolved_cnt2), 32'h0);
        chk("clr_taken", 32'(taken_cnt2), 32'h0);
        chk("clr_redirect", 32'(redirect2), 32'h1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Downstream of the EX-stage ALU/branch unit. Consumes the resolved branch condition, target and link address for each EX instruction.
- Issues a registered PC redirect to fetch and flushes the wrong-path IF/ID and ID/EX contents under a predict-not-taken scheme.
- Generates the JAL/JALR link write-back pulse and keeps resolved/taken performance counters.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush_ifid/flush_idex stay asserted per taken redirect (legal 1..7).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  pipeline stall from memory stage; freezes this block.
- ex_valid  in  1  EX holds a valid, non-squashed instruction.
- ex_branch  in  1  EX instruction is a branch or jump.
- ex_jal  in  1  EX instruction is a linking jump (JAL/JALR).
- branch_con  in  1  taken indication from the ALU/branch unit.
- ex_target  in  16  computed branch/jump target.
- ex_pc2  in  16  PC+2 of the EX instruction (link value).
- clr_cnt  in  1  synchronous clear of both counters.
- redirect  out  1  fetch must load redirect_pc.
- redirect_pc  out  16  registered target.
- flush_ifid  out  1  squash the IF/ID register.
- flush_idex  out  1  squash the ID/EX register.
- link_we  out  1  write link_data to R7.
- link_data  out  16  registered ex_pc2.
- resolved_cnt  out  CNT_W  branches/jumps resolved on the correct path.
- taken_cnt  out  CNT_W  resolved branches that were taken.
- err  out  1  sticky illegal-input flag.

Behaviour:

Reset (rst=0, asynchronous):
- All outputs 0, state=IDLE, flush counter 0, counters 0.

Resolve event:
- res = ex_valid & ex_branch & ~stall, sampled at the rising edge.
- res is sampled only in IDLE. In REDIRECT and FLUSH the EX instruction is wrong-path: it is ignored and no counter is incremented.

FSM states:
- IDLE
  - res & branch_con: go to REDIRECT. Register redirect_pc <= ex_target. If ex_jal, register link_data <= ex_pc2.
  - res & ~branch_con: stay in IDLE; only resolved_cnt increments.
- REDIRECT
  - Outputs: redirect=1, flush_ifid=1, flush_idex=1, link_we=1 only if the resolving instruction was ex_jal.
  - Latency: outputs appear exactly 1 cycle after the resolve edge.
  - stall=1: hold state and all outputs; redirect stays asserted until consumed.
  - stall=0 and FLUSH_CYCLES=1: go to IDLE.
  - stall=0 and FLUSH_CYCLES>1: go to FLUSH with flush counter <= FLUSH_CYCLES-2.
- FLUSH
  - Outputs: flush_ifid=1, flush_idex=1, redirect=0, link_we=0.
  - stall=1: hold.
  - stall=0: decrement the counter; at 0, go to IDLE.
- Total flush assertion per redirect = FLUSH_CYCLES non-stalled cycles, including REDIRECT.
- redirect_pc and link_data hold their last value outside REDIRECT.

Counters:
- On res in IDLE: resolved_cnt += 1; taken_cnt += 1 if branch_con.
- Both counters saturate at all-ones; they never wrap.
- clr_cnt=1 zeroes both counters and wins over a simultaneous increment.
- Counters are not frozen by stall; increments occur only on res, which already requires ~stall.

err:
- Set when ex_valid & ex_jal & ~ex_branch, or when ex_valid & ex_jal & ~branch_con, in any state.
- Sticky until reset.
- Does not alter FSM behaviour.

Back-to-back:
- A taken branch resolved on the same edge that FLUSH returns to IDLE is not sampled; that EX slot is still wrong-path.
- The first sample point is the first edge spent in IDLE.

Mid-operation reset:
- Asynchronous return to IDLE with all outputs 0, from any state.

Test Plan:
- Reset release, then IDLE with no activity for 5 cycles -> all outputs remain 0, both counters 0.
- Not-taken branch (ex_valid=1, ex_branch=1, branch_con=0) -> redirect never asserts; resolved_cnt=1, taken_cnt=0.
- Taken branch with ex_target=16'h0040 and FLUSH_CYCLES=2 -> next cycle redirect=1, redirect_pc=16'h0040, flushes=1; following cycle flushes=1, redirect=0; then IDLE. A second taken branch presented during FLUSH is ignored (taken_cnt=1).
- JAL taken with ex_pc2=16'h0012 and stall raised for 3 cycles during REDIRECT -> redirect, link_we and flushes held for 4 cycles; link_data=16'h0012; release proceeds to FLUSH.
- Saturation with CNT_W=2: 5 resolved taken branches -> both counters read 3. clr_cnt asserted concurrently with a 6th resolve -> both counters read 0.
- Assert rst=0 in the middle of FLUSH, asynchronous to clk -> outputs drop to 0 immediately; after release, err=0 and the block is in IDLE.
